// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding word read per CPU fetch, held until consumed.
// Optional WAIT timeout is enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        instr_taken,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("instr_fetch: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        mem_req_q, mem_req_d;
    logic        busy_q, busy_d;

`ifdef INSTR_FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Next-state and next-output logic; mem_addr_q doubles as the latched fetch address.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        mem_req_d     = mem_req_q;
        busy_d        = busy_q;
`ifdef INSTR_FETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    if (pc[1:0] == 2'b00) begin
                        state_d    = S_WAIT;
                        mem_req_d  = 1'b1;
                        busy_d     = 1'b1;
                        mem_addr_d = pc;
`ifdef INSTR_FETCH_TIMEOUT_EN
                        cnt_d      = 8'd0;
`endif
                    end else begin
                        state_d       = S_HOLD;
                        instruction_d = NOP_WORD;
                        fetch_fault_d = 1'b1;
                        instr_valid_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    // A redirected pc drops the returned word and refetches from IDLE.
                    if (pc == mem_addr_q) begin
                        state_d       = S_HOLD;
                        instruction_d = mem_rdata;
                        fetch_fault_d = 1'b0;
                        instr_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`ifdef INSTR_FETCH_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = S_HOLD;
                    mem_req_d     = 1'b0;
                    busy_d        = 1'b0;
                    instruction_d = NOP_WORD;
                    fetch_fault_d = 1'b1;
                    instr_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_HOLD: begin
                if (instr_taken) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                    fetch_fault_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instruction_q <= NOP_WORD;
            mem_addr_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
            cnt_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            mem_req_q     <= mem_req_d;
            busy_q        <= busy_d;
`ifdef INSTR_FETCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner sequences, random vs reference model.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        fetch_en = 1'b0;
    logic        instr_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] instruction, mem_addr;
    logic        instr_valid, fetch_fault, busy, mem_req;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one outstanding request, one presented word.
    bit          m_out, m_pres, m_fault;
    logic [31:0] m_addr, m_word;
    int          m_waited;

    instr_fetch #(.TIMEOUT_CYCLES(TO), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .instr_taken(instr_taken),
        .instruction(instruction), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic [31:0] pc;
        logic        taken;
        logic        ack;
        logic [31:0] rdata;
        logic        ev, er, ef;
        logic [31:0] ei, ea;
    } vec_t;

    vec_t tbl [6];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic er, input logic ef,
                                 input logic [31:0] ei, input logic [31:0] ea);
        vectors++;
        cmp({tag, ".instr_valid"}, 32'(instr_valid), 32'(ev));
        cmp({tag, ".mem_req"},     32'(mem_req),     32'(er));
        cmp({tag, ".busy"},        32'(busy),        32'(er));
        cmp({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(ef));
        cmp({tag, ".instruction"}, instruction, ei);
        cmp({tag, ".mem_addr"},    mem_addr, ea);
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_pres, m_out, m_fault, m_word, m_addr);
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_pres = 1'b0; m_fault = 1'b0;
        m_addr = 32'd0; m_word = NOP; m_waited = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_out) begin
            if (mem_ack) begin
                m_out = 1'b0;
                if (pc == m_addr) begin
                    m_pres = 1'b1; m_word = mem_rdata; m_fault = 1'b0;
                end
            end else begin
                m_waited++;
`ifdef INSTR_FETCH_TIMEOUT_EN
                if (m_waited == TO) begin
                    m_out = 1'b0; m_pres = 1'b1; m_word = NOP; m_fault = 1'b1;
                end
`endif
            end
        end else if (m_pres) begin
            if (instr_taken) begin
                m_pres = 1'b0; m_fault = 1'b0;
            end
        end else if (fetch_en) begin
            if (pc[1:0] != 2'b00) begin
                m_pres = 1'b1; m_word = NOP; m_fault = 1'b1;
            end else begin
                m_out = 1'b1; m_addr = pc; m_waited = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic fe, input logic [31:0] p, input logic tk,
                         input logic ack, input logic [31:0] rd);
        fetch_en = fe; pc = p; instr_taken = tk; mem_ack = ack; mem_rdata = rd;
    endtask

    initial begin
        // basic fetch, misaligned fetch, HOLD ignoring pc change and ack
        tbl[0] = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, NOP,          32'h0};
        tbl[1] = '{1'b1, 32'h00, 1'b0, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0, 32'h1234_ABCD, 32'h0};
        tbl[2] = '{1'b0, 32'h04, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h1234_ABCD, 32'h0};
        tbl[3] = '{1'b1, 32'h22, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, NOP,          32'h0};
        tbl[4] = '{1'b1, 32'h30, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, NOP,          32'h0};
        tbl[5] = '{1'b0, 32'h30, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, NOP,          32'h0};

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_outputs("reset_async", 1'b0, 1'b0, 1'b0, NOP, 32'h0);
        model_reset();
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].fe, tbl[i].pc, tbl[i].taken, tbl[i].ack, tbl[i].rdata);
            step();
            check_outputs($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].er, tbl[i].ef, tbl[i].ei, tbl[i].ea);
        end

        // stall: ack held off for 5 cycles
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("stall_start", 1'b0, 1'b1, 1'b0, NOP, 32'h10);
        for (int i = 0; i < 5; i++) begin
            step();
            check_outputs($sformatf("stall[%0d]", i), 1'b0, 1'b1, 1'b0, NOP, 32'h10);
        end
        drive(1'b0, 32'h10, 1'b0, 1'b1, 32'hA5A5_0010);
        step();
        check_outputs("stall_ack", 1'b1, 1'b0, 1'b0, 32'hA5A5_0010, 32'h10);
        drive(1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
        step();
        check_outputs("stall_taken", 1'b0, 1'b0, 1'b0, 32'hA5A5_0010, 32'h10);

        // redirect during WAIT discards the returned word
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("redir_req", 1'b0, 1'b1, 1'b0, 32'hA5A5_0010, 32'h20);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("redir_pc", 1'b0, 1'b1, 1'b0, 32'hA5A5_0010, 32'h20);
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step();
        check_outputs("redir_drop", 1'b0, 1'b0, 1'b0, 32'hA5A5_0010, 32'h20);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("redir_refetch", 1'b0, 1'b1, 1'b0, 32'hA5A5_0010, 32'h40);
        drive(1'b0, 32'h40, 1'b0, 1'b1, 32'h4040_4040);
        step();
        check_outputs("redir_data", 1'b1, 1'b0, 1'b0, 32'h4040_4040, 32'h40);
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
        step();
        check_outputs("redir_taken", 1'b0, 1'b0, 1'b0, 32'h4040_4040, 32'h40);

        drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("long_wait_start", 1'b0, 1'b1, 1'b0, 32'h4040_4040, 32'h50);
        fetch_en = 1'b0;
        for (int i = 1; i < TO; i++) begin
            step();
            check_outputs($sformatf("long_wait[%0d]", i), 1'b0, 1'b1, 1'b0, 32'h4040_4040, 32'h50);
        end
`ifdef INSTR_FETCH_TIMEOUT_EN
        step();
        check_outputs("timeout", 1'b1, 1'b0, 1'b1, NOP, 32'h50);
        drive(1'b0, 32'h50, 1'b0, 1'b1, 32'h0BAD_0BAD);
        step();
        check_outputs("late_ack", 1'b1, 1'b0, 1'b1, NOP, 32'h50);
        drive(1'b0, 32'h50, 1'b1, 1'b0, 32'h0);
        step();
        check_outputs("timeout_taken", 1'b0, 1'b0, 1'b0, NOP, 32'h50);
`else
        for (int i = 0; i < 4; i++) begin
            step();
            check_outputs($sformatf("no_timeout[%0d]", i), 1'b0, 1'b1, 1'b0, 32'h4040_4040, 32'h50);
        end
        drive(1'b0, 32'h50, 1'b0, 1'b1, 32'h5050_5050);
        step();
        check_outputs("no_timeout_ack", 1'b1, 1'b0, 1'b0, 32'h5050_5050, 32'h50);
        drive(1'b0, 32'h50, 1'b1, 1'b0, 32'h0);
        step();
        check_outputs("no_timeout_taken", 1'b0, 1'b0, 1'b0, 32'h5050_5050, 32'h50);
`endif

        // reset mid-WAIT, ack during and after reset ignored
        drive(1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("rst_wait_req", 1'b0, 1'b1, 1'b0, m_word, 32'h60);
        #2 rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_0060;
        #1 check_outputs("rst_mid_wait", 1'b0, 1'b0, 1'b0, NOP, 32'h0);
        model_reset();
        step();
        rst = 1'b0;
        drive(1'b0, 32'h60, 1'b0, 1'b1, 32'h0BAD_0060);
        step();
        check_outputs("rst_ack_ignored", 1'b0, 1'b0, 1'b0, NOP, 32'h0);
        drive(1'b1, 32'h64, 1'b0, 1'b0, 32'h0);
        step();
        check_outputs("rst_refetch", 1'b0, 1'b1, 1'b0, NOP, 32'h64);
        drive(1'b0, 32'h64, 1'b0, 1'b1, 32'h6464_6464);
        step();
        check_outputs("rst_refetch_data", 1'b1, 1'b0, 1'b0, 32'h6464_6464, 32'h64);

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(99) == 0);
            fetch_en = ($urandom_range(9) < 7);
            if ($urandom_range(4) == 0) begin
                pc = 32'($urandom_range(15)) << 2;
                if ($urandom_range(7) == 0) pc = pc + 32'($urandom_range(3, 1));
            end
            instr_taken = 1'($urandom_range(1));
            mem_ack = ($urandom_range(9) < 4);
            mem_rdata = $urandom;
            step();
            check_model($sformatf("rand[%0d]", i));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
